// File: rtl/acacia_rr_grant.sv
// Round-robin grant controller: one-hot grant held until release, cancel or tenure cap.
// All outputs come straight from flops; next-state logic computes their next values.
module acacia_rr_grant #(
  parameter int unsigned NCLIENT  = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = $clog2(NCLIENT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               cancel,
  input  logic [NCLIENT-1:0] req,
  output logic [NCLIENT-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               expired
);

  localparam int unsigned    HCW     = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HoldMax = HCW'(MAX_HOLD);
  localparam logic [IDW:0]   NcW     = (IDW + 1)'(NCLIENT);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [NCLIENT-1:0] mask_q, mask_d;
  logic [NCLIENT-1:0] mask_set;

  logic [NCLIENT-1:0] grant_d;
  logic [IDW-1:0]     grant_id_d;
  logic               busy_d;
  logic               expired_d;

  // Arbitration: rotate eligibility so the search always starts at bit 0.
  logic [NCLIENT-1:0] elig;
  logic [NCLIENT-1:0] elig_rot;
  logic               found;
  logic [IDW-1:0]     rot_off;
  logic [IDW:0]       pick_sum;
  logic [IDW:0]       pick_inc;
  logic [IDW-1:0]     pick;
  logic [IDW-1:0]     ptr_after;

  assign elig     = req & ~mask_q;
  assign elig_rot = NCLIENT'({elig, elig} >> ptr_q);

  always_comb begin
    found   = 1'b0;
    rot_off = '0;
    for (int k = 0; k < int'(NCLIENT); k++) begin
      if (!found && elig_rot[k]) begin
        found   = 1'b1;
        rot_off = IDW'(k);
      end
    end
  end

  assign pick_sum  = {1'b0, ptr_q} + {1'b0, rot_off};
  assign pick      = (pick_sum >= NcW) ? IDW'(pick_sum - NcW) : IDW'(pick_sum);
  assign pick_inc  = {1'b0, pick} + (IDW + 1)'(1);
  assign ptr_after = (pick_inc >= NcW) ? '0 : IDW'(pick_inc);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    mask_set  = '0;
    expired_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go && found) begin
          state_d = StGrant;
          owner_d = pick;
          hold_d  = HCW'(1);
          ptr_d   = ptr_after;
        end
      end
      StGrant: begin
        // Release priority: cancel, owner drop, tenure cap.
        if (cancel) begin
          state_d  = StIdle;
          hold_d   = '0;
          mask_set = NCLIENT'(1) << owner_q;
        end else if (!req[owner_q]) begin
          state_d = StIdle;
          hold_d  = '0;
        end else if (hold_q == HoldMax) begin
          state_d   = StIdle;
          hold_d    = '0;
          expired_d = 1'b1;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A set in this cycle wins over the clear from a low request.
  assign mask_d = (mask_q & req) | mask_set;

  always_comb begin
    grant_d    = '0;
    grant_id_d = '0;
    busy_d     = 1'b0;
    if (state_d == StGrant) begin
      grant_d    = NCLIENT'(1) << owner_d;
      grant_id_d = owner_d;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      hold_q   <= '0;
      mask_q   <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      mask_q   <= mask_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      expired  <= expired_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_busy_match:   assert property (@(posedge clk) disable iff (reset) busy == (grant != '0));
  a_exp_idle:     assert property (@(posedge clk) disable iff (reset) expired |-> !busy);

endmodule
